dab_param_scheduler: RTL and testbench
======================================

// Module: dab_param_scheduler
// PURPOSE
//  Sequencer/configurator for the DAB gate-voltage generator (voltajes). Owns its
//  t1/t2/phi/sync/CE inputs: runs start-up sync, slew-limits modulation parameter
//  changes (one step per switching period, at trigger), handles stop ramp-down and
//  fault shutdown. Sits between the supervisory/host register interface and voltajes.
// PARAMETERS
//  STEP          8      max |change| per parameter per switching period (LSB; 256 LSB = pi)
//  SYNC_LEN      10     sync pulse length, clk cycles
//  TRIG_TIMEOUT  200000 max clk cycles between trigger edges in RAMP/RUN/STOP before fault
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-low reset
//  en         in   1  level: 1 = converter requested on
//  load       in   1  1-cycle strobe: latch t1_tgt/t2_tgt/phi_tgt
//  t1_tgt     in   9  target t1, unsigned 0..255
//  t2_tgt     in   9  target t2, unsigned 0..255
//  phi_tgt    in   9  target phi, two's complement -255..255
//  trigger    in   1  period marker from voltajes (rising edge = period start)
//  fault_in   in   1  external fault (overcurrent etc.), level
//  fault_clr  in   1  1-cycle strobe: leave FAULT
//  t1         out  9  to voltajes.t1
//  t2         out  9  to voltajes.t2
//  phi        out  9  to voltajes.phi
//  sync       out  1  to voltajes.sync
//  CE         out  1  to voltajes.CE
//  ready      out  1  1 in RUN (outputs equal targets)
//  state      out  3  current FSM state encoding
//  fault_code out  2  0 none, 1 external, 2 trigger timeout; sticky until fault_clr
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, t1=t2=phi=0, targets=0, sync=0, CE=0, ready=0,
//   fault_code=0, timeout counter=0, trigger edge register=0. All outputs registered.
//  Target latch: load=1 in any state but FAULT latches clamped targets next edge;
//   t1/t2 with bit8 set -> 255; phi=-256 (9'h100) -> -255. load ignored in FAULT.
//  FSM (priority: fault > en drop > rest):
//   IDLE : CE=0, params 0. en=1 -> SYNC.
//   SYNC : CE=1, sync=1 for exactly SYNC_LEN cycles, params 0 -> RAMP.
//   RAMP : per trigger rising edge each param moves toward its target by
//          min(STEP,|tgt-cur|); diff computed 10-bit signed. All equal -> RUN
//          (same edge as final step; ready=1 next cycle).
//   RUN  : ready=1. load with any target != output -> RAMP.
//   STOP : entered on en=0 from SYNC/RAMP/RUN; targets ignored, params ramp to 0
//          per trigger edge; all 0 -> IDLE (CE drops). en=1 in STOP -> RAMP.
//   FAULT: fault_in=1 in any non-IDLE state, or no trigger edge for TRIG_TIMEOUT
//          cycles in RAMP/RUN/STOP. Same edge: CE=0, sync=0, params=0, ready=0.
//          fault_clr with fault_in=0 -> IDLE (fault_code cleared); otherwise stays.
//  Outputs change only on trigger edges (or to 0 on FAULT/IDLE) -> no mid-period
//   glitch at voltajes. load and trigger in same cycle: step uses OLD targets.
//  Timeout counter resets on each trigger edge and on any state entry; saturates.
//  fault_in in IDLE: ignored (converter off), en=1 with fault_in=1 -> FAULT next edge.
// STRUCTURE
//  Package dab_pkg: state encodings (IDLE,SYNC,RAMP,RUN,STOP,FAULT), fault codes,
//   T_MAX=255, PHI_MAX=255, PARAM_W=9.
//  Sub-module dab_param_slew (x3): cur/tgt/step -> next value + at_target flag,
//   SIGNED parameter selects unsigned/two's-complement compare.
//  Top: FSM, trigger edge detect, sync and timeout counters, target registers.
// TESTING
//  Start-up: en=1, tgt t1=223,t2=128,phi=64, STEP=8, trigger every 1000 clk ->
//   sync high 10 cycles, then t1 steps 0,8,..,216,223 (28 periods), ready after.
//  Negative phi: RUN at phi=64, load phi=-32 -> phi 56,48,..,-24,-32 over 12 periods.
//  Clamp: load t1=9'h1FF, phi=9'h100 -> ramps to t1=255, phi=-255 (9'h101).
//  Fault: in RAMP raise fault_in -> next edge CE=0, params 0, fault_code=1;
//   fault_clr while fault_in=1 -> stays FAULT; after drop + clr -> IDLE.
//  Timeout: stop trigger in RUN -> FAULT at 200000 cycles, fault_code=2.
//  Stop/async reset: en=0 in RUN -> ramp to 0 then IDLE, CE=0; rst=0 mid-RAMP ->
//   all outputs 0 immediately (no clk edge).

Source files
------------

// File: rtl/dab_pkg.sv
// Shared encodings and widths for the DAB parameter scheduler and its slew limiters.
package dab_pkg;

    localparam int PARAM_W = 9;
    localparam int T_MAX   = 255;
    localparam int PHI_MAX = 255;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_RAMP  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_EXT     = 2'd1,
        FC_TIMEOUT = 2'd2
    } fault_code_t;

endpackage

// File: rtl/dab_param_slew.sv
// One-parameter slew limiter: moves cur toward tgt by at most step.
// at_target means the proposed next value has reached the target.
module dab_param_slew
    import dab_pkg::*;
#(
    parameter int SIGNED = 0
) (
    input  logic [PARAM_W-1:0] cur,
    input  logic [PARAM_W-1:0] tgt,
    input  logic [PARAM_W-1:0] step,
    output logic [PARAM_W-1:0] nxt,
    output logic               at_target
);

    logic signed [PARAM_W:0] cur_e;
    logic signed [PARAM_W:0] tgt_e;
    logic signed [PARAM_W:0] diff;
    logic signed [PARAM_W:0] step_pos;
    logic signed [PARAM_W:0] step_neg;

    // One extra bit keeps the full -510..510 difference representable.
    always_comb begin
        cur_e    = (SIGNED != 0) ? {cur[PARAM_W-1], cur} : {1'b0, cur};
        tgt_e    = (SIGNED != 0) ? {tgt[PARAM_W-1], tgt} : {1'b0, tgt};
        diff     = tgt_e - cur_e;
        step_pos = $signed({1'b0, step});
        step_neg = -step_pos;
        if (diff > step_pos) begin
            nxt = cur + step;
        end else if (diff < step_neg) begin
            nxt = cur - step;
        end else begin
            nxt = tgt;
        end
        at_target = (nxt == tgt);
    end

endmodule

// File: rtl/dab_param_scheduler.sv
// Sequencer for the DAB gate-voltage generator: start-up sync, per-period slew of
// t1/t2/phi, stop ramp-down and fault shutdown. All outputs are registered.
module dab_param_scheduler
    import dab_pkg::*;
#(
    parameter int STEP         = 8,
    parameter int SYNC_LEN     = 10,
    parameter int TRIG_TIMEOUT = 200000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic        [PARAM_W-1:0] t1_tgt,
    input  logic        [PARAM_W-1:0] t2_tgt,
    input  logic signed [PARAM_W-1:0] phi_tgt,
    input  logic                      trigger,
    input  logic                      fault_in,
    input  logic                      fault_clr,
    output logic        [PARAM_W-1:0] t1,
    output logic        [PARAM_W-1:0] t2,
    output logic signed [PARAM_W-1:0] phi,
    output logic                      sync,
    output logic                      CE,
    output logic                      ready,
    output logic        [2:0]         state,
    output logic        [1:0]         fault_code
);

    localparam int SC_W = $clog2(SYNC_LEN + 1);
    localparam int TC_W = $clog2(TRIG_TIMEOUT + 1);
    localparam logic [PARAM_W-1:0] STEP_V      = PARAM_W'(STEP);
    localparam logic [PARAM_W-1:0] T_SAT       = PARAM_W'(T_MAX);
    localparam logic [PARAM_W-1:0] PHI_NEG_MAX = PARAM_W'(-PHI_MAX);
    localparam logic [PARAM_W-1:0] PHI_MIN_RAW = {1'b1, {(PARAM_W-1){1'b0}}};

    function automatic logic [PARAM_W-1:0] sat_t(input logic [PARAM_W-1:0] v);
        return v[PARAM_W-1] ? T_SAT : v;
    endfunction

    // -256 has no positive mirror, so it is pulled in to -255.
    function automatic logic [PARAM_W-1:0] sat_phi(input logic [PARAM_W-1:0] v);
        return (v == PHI_MIN_RAW) ? PHI_NEG_MAX : v;
    endfunction

    logic [2:0]         next_state;
    logic               trig_q;
    logic               trig_rise;
    logic [PARAM_W-1:0] t1_tr, t2_tr, phi_tr;
    logic [PARAM_W-1:0] t1_ld, t2_ld, phi_ld;
    logic [PARAM_W-1:0] t1_sl, t2_sl, phi_sl;
    logic [PARAM_W-1:0] t1_nxt, t2_nxt, phi_nxt;
    logic               t1_at, t2_at, phi_at;
    logic               all_at;
    logic               ld_changed;
    logic               tgt_differs;
    logic               params_zero;
    logic               timeout_st;
    logic               timeout_hit;
    logic [SC_W-1:0]    sync_cnt;
    logic [TC_W-1:0]    to_cnt;

    assign trig_rise   = trigger & ~trig_q;
    assign t1_ld       = sat_t(t1_tgt);
    assign t2_ld       = sat_t(t2_tgt);
    assign phi_ld      = sat_phi(phi_tgt);
    assign ld_changed  = (t1_ld != t1) || (t2_ld != t2) || (phi_ld != phi);
    assign tgt_differs = (t1_tr != t1) || (t2_tr != t2) || (phi_tr != phi);
    assign params_zero = (t1 == '0) && (t2 == '0) && (phi == '0);
    assign all_at      = t1_at && t2_at && phi_at;
    assign timeout_st  = (state == ST_RAMP) || (state == ST_RUN) || (state == ST_STOP);
    assign timeout_hit = timeout_st && !trig_rise && (to_cnt >= TC_W'(TRIG_TIMEOUT - 1));

    // While stopping, stored targets are ignored and everything ramps to zero.
    assign t1_sl  = (state == ST_STOP) ? '0 : t1_tr;
    assign t2_sl  = (state == ST_STOP) ? '0 : t2_tr;
    assign phi_sl = (state == ST_STOP) ? '0 : phi_tr;

    dab_param_slew #(.SIGNED(0)) u_slew_t1 (
        .cur(t1), .tgt(t1_sl), .step(STEP_V), .nxt(t1_nxt), .at_target(t1_at)
    );
    dab_param_slew #(.SIGNED(0)) u_slew_t2 (
        .cur(t2), .tgt(t2_sl), .step(STEP_V), .nxt(t2_nxt), .at_target(t2_at)
    );
    dab_param_slew #(.SIGNED(1)) u_slew_phi (
        .cur(phi), .tgt(phi_sl), .step(STEP_V), .nxt(phi_nxt), .at_target(phi_at)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (en) next_state = fault_in ? ST_FAULT : ST_SYNC;
            end
            ST_SYNC: begin
                if (fault_in)                              next_state = ST_FAULT;
                else if (!en)                              next_state = ST_STOP;
                else if (sync_cnt == SC_W'(SYNC_LEN - 1))  next_state = ST_RAMP;
            end
            ST_RAMP: begin
                if (fault_in || timeout_hit)               next_state = ST_FAULT;
                else if (!en)                              next_state = ST_STOP;
                else if (trig_rise && all_at)              next_state = ST_RUN;
            end
            ST_RUN: begin
                if (fault_in || timeout_hit)               next_state = ST_FAULT;
                else if (!en)                              next_state = ST_STOP;
                else if ((load && ld_changed) || tgt_differs) next_state = ST_RAMP;
            end
            ST_STOP: begin
                if (fault_in || timeout_hit)               next_state = ST_FAULT;
                else if (en)                               next_state = ST_RAMP;
                else if (params_zero || (trig_rise && all_at)) next_state = ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr && !fault_in)                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, counters and control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            trig_q     <= 1'b0;
            sync_cnt   <= '0;
            to_cnt     <= '0;
            sync       <= 1'b0;
            CE         <= 1'b0;
            ready      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            state  <= next_state;
            trig_q <= trigger;
            sync   <= (next_state == ST_SYNC);
            CE     <= (next_state == ST_SYNC) || (next_state == ST_RAMP) ||
                      (next_state == ST_RUN)  || (next_state == ST_STOP);
            ready  <= (next_state == ST_RUN);

            if ((state == ST_SYNC) && (next_state == ST_SYNC))
                sync_cnt <= sync_cnt + SC_W'(1);
            else
                sync_cnt <= '0;

            if (!timeout_st || trig_rise || (next_state != state))
                to_cnt <= '0;
            else if (to_cnt != TC_W'(TRIG_TIMEOUT))
                to_cnt <= to_cnt + TC_W'(1);

            if ((state != ST_FAULT) && (next_state == ST_FAULT))
                fault_code <= fault_in ? FC_EXT : FC_TIMEOUT;
            else if ((state == ST_FAULT) && (next_state == ST_IDLE))
                fault_code <= FC_NONE;
        end
    end

    // Targets and modulation parameters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t1_tr  <= '0;
            t2_tr  <= '0;
            phi_tr <= '0;
            t1     <= '0;
            t2     <= '0;
            phi    <= '0;
        end else begin
            if (load && (state != ST_FAULT)) begin
                t1_tr  <= t1_ld;
                t2_tr  <= t2_ld;
                phi_tr <= phi_ld;
            end
            if ((next_state == ST_IDLE) || (next_state == ST_SYNC) || (next_state == ST_FAULT)) begin
                t1  <= '0;
                t2  <= '0;
                phi <= '0;
            end else if (trig_rise && ((state == ST_RAMP) || (state == ST_STOP))) begin
                t1  <= t1_nxt;
                t2  <= t2_nxt;
                phi <= phi_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dab_param_scheduler.sv
// Bench for dab_param_scheduler: expected t1/t2/phi steps are queued per scenario
// and compared each time the outputs move.
module tb_dab_param_scheduler;

    localparam int TP      = 40;
    localparam int TMO     = 500;
    localparam int SYNC_L  = 10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_RAMP  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    typedef struct packed {
        logic [8:0] t1;
        logic [8:0] t2;
        logic [8:0] phi;
    } tup_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [8:0] t1_tgt = '0;
    logic [8:0] t2_tgt = '0;
    logic [8:0] phi_tgt = '0;
    logic       trigger = 1'b0;
    logic       fault_in = 1'b0;
    logic       fault_clr = 1'b0;
    logic [8:0] t1, t2, phi;
    logic       sync, CE, ready;
    logic [2:0] state;
    logic [1:0] fault_code;

    logic       trig_en = 1'b0;
    logic       mon_on = 1'b0;
    tup_t       exp_q[$];
    tup_t       prev = '0;
    int         n_chk = 0;
    int         n_fail = 0;

    dab_param_scheduler #(.STEP(8), .SYNC_LEN(SYNC_L), .TRIG_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .t1_tgt(t1_tgt), .t2_tgt(t2_tgt), .phi_tgt(phi_tgt),
        .trigger(trigger), .fault_in(fault_in), .fault_clr(fault_clr),
        .t1(t1), .t2(t2), .phi(phi), .sync(sync), .CE(CE), .ready(ready),
        .state(state), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void push_tup(input int a, input int b, input int c);
        tup_t e;
        e.t1  = 9'(a);
        e.t2  = 9'(b);
        e.phi = 9'(c);
        exp_q.push_back(e);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Trigger: square wave of period TP while enabled.
    initial begin
        forever begin
            repeat (TP / 2) @(posedge clk);
            trigger = trig_en;
            repeat (TP / 2) @(posedge clk);
            trigger = 1'b0;
        end
    end

    // Output monitor: every change of the parameter triple consumes one expectation.
    always @(negedge clk) begin
        tup_t cur;
        cur = {t1, t2, phi};
        if (rst && (cur != prev)) begin
            if (mon_on) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_step", int'(cur), int'(prev));
                end else begin
                    tup_t e;
                    e = exp_q.pop_front();
                    check("step_t1", int'(cur.t1), int'(e.t1));
                    check("step_t2", int'(cur.t2), int'(e.t2));
                    check("step_phi", int'(cur.phi), int'(e.phi));
                end
            end
        end
        prev = cur;
    end

    task automatic do_load(input int a, input int b, input int c);
        @(negedge clk);
        t1_tgt  = 9'(a);
        t2_tgt  = 9'(b);
        phi_tgt = 9'(c);
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(state), int'(s));
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int n;

        // Reset state
        #12;
        check("rst_t1", int'(t1), 0);
        check("rst_phi", int'(phi), 0);
        check("rst_CE", int'(CE), 0);
        check("rst_sync", int'(sync), 0);
        check("rst_state", int'(state), int'(S_IDLE));
        check("rst_fault_code", int'(fault_code), 0);
        @(negedge clk);
        rst = 1'b1;

        // Start-up: sync pulse, then 28-period ramp to (223,128,64)
        do_load(223, 128, 64);
        for (int k = 1; k <= 28; k++) push_tup(imin(8 * k, 223), imin(8 * k, 128), imin(8 * k, 64));
        mon_on  = 1'b1;
        trig_en = 1'b1;
        @(negedge clk);
        en = 1'b1;
        n = 0;
        while (!sync && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sync_seen", int'(sync), 1);
        check("sync_CE", int'(CE), 1);
        check("sync_state", int'(state), int'(S_SYNC));
        n = 0;
        while (sync && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("sync_len", n, SYNC_L);
        check("ramp_not_ready", int'(ready), 0);
        wait_drain(32 * TP, "startup_drain");
        repeat (2) @(negedge clk);
        check("startup_ready", int'(ready), 1);
        check("startup_state", int'(state), int'(S_RUN));

        // Negative phi: 64 -> -32 in 12 periods
        for (int k = 1; k <= 12; k++) push_tup(223, 128, 64 - 8 * k);
        do_load(223, 128, -32);
        @(negedge clk);
        check("neg_ready_drop", int'(ready), 0);
        wait_drain(16 * TP, "neg_drain");
        repeat (2) @(negedge clk);
        check("neg_ready", int'(ready), 1);

        // Clamp: 9'h1FF -> 255, 9'h100 -> -255
        for (int k = 1; k <= 28; k++) push_tup(imin(223 + 8 * k, 255), 128, imax(-32 - 8 * k, -255));
        do_load(9'h1FF, 128, 9'h100);
        wait_drain(32 * TP, "clamp_drain");
        repeat (2) @(negedge clk);
        check("clamp_t1", int'(t1), 255);
        check("clamp_phi", int'(phi), 9'h101);
        check("clamp_ready", int'(ready), 1);

        // Stop: ramp everything to zero, then IDLE with CE low
        for (int k = 1; k <= 32; k++) push_tup(imax(255 - 8 * k, 0), imax(128 - 8 * k, 0), imin(-255 + 8 * k, 0));
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("stop_state", int'(state), int'(S_STOP));
        wait_drain(36 * TP, "stop_drain");
        repeat (2) @(negedge clk);
        check("stop_idle", int'(state), int'(S_IDLE));
        check("stop_CE", int'(CE), 0);

        // External fault in RAMP
        mon_on = 1'b0;
        en = 1'b1;
        wait_state(S_RAMP, 100, "fault_reach_ramp");
        repeat (3 * TP) @(negedge clk);
        check("fault_pre_t1_nonzero", int'(t1 != 0), 1);
        fault_in = 1'b1;
        @(posedge clk);
        #1;
        check("fault_state", int'(state), int'(S_FAULT));
        check("fault_CE", int'(CE), 0);
        check("fault_t1", int'(t1), 0);
        check("fault_phi", int'(phi), 0);
        check("fault_ready", int'(ready), 0);
        check("fault_code_ext", int'(fault_code), 1);
        pulse_clr();
        check("fault_clr_held", int'(state), int'(S_FAULT));
        @(negedge clk);
        fault_in = 1'b0;
        en = 1'b0;
        pulse_clr();
        check("fault_clr_idle", int'(state), int'(S_IDLE));
        check("fault_code_cleared", int'(fault_code), 0);

        // Trigger timeout in RUN
        do_load(16, 16, 0);
        push_tup(8, 8, 0);
        push_tup(16, 16, 0);
        mon_on = 1'b1;
        @(negedge clk);
        en = 1'b1;
        wait_state(S_RUN, 8 * TP, "tmo_reach_run");
        wait_drain(4 * TP, "tmo_drain");
        mon_on = 1'b0;
        trig_en = 1'b0;
        repeat (400) @(negedge clk);
        check("tmo_still_run", int'(state), int'(S_RUN));
        repeat (160) @(negedge clk);
        check("tmo_fault", int'(state), int'(S_FAULT));
        check("tmo_code", int'(fault_code), 2);
        check("tmo_CE", int'(CE), 0);
        en = 1'b0;
        pulse_clr();
        check("tmo_clr_idle", int'(state), int'(S_IDLE));

        // Asynchronous reset mid-RAMP
        trig_en = 1'b1;
        do_load(200, 200, 100);
        @(negedge clk);
        en = 1'b1;
        wait_state(S_RAMP, 100, "arst_reach_ramp");
        repeat (3 * TP) @(negedge clk);
        check("arst_pre_phi_nonzero", int'(phi != 0), 1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_t1", int'(t1), 0);
        check("arst_t2", int'(t2), 0);
        check("arst_phi", int'(phi), 0);
        check("arst_CE", int'(CE), 0);
        check("arst_state", int'(state), int'(S_IDLE));
        check("arst_ready", int'(ready), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
